decoder_cpu_oci_access_sequencer: RTL and testbench
===================================================

DECODER_CPU_OCI_ACCESS_SEQUENCER -- requirements
Module: decoder_cpu_oci_access_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning word-address width of the on-chip debug RAM.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 15, meaning the maximum number of cycles to wait for ram_ack.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named as in the codebase.
REQ-004 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  JTAG data captured in the sysclk domain.
- take_action_ocimem_a  in  1  command strobe: jdo[35]=read(1)/write(0), jdo[34]=auto-increment, jdo[ADDR_W+9:10]=address.
- take_action_ocimem_b  in  1  write-data strobe: jdo[34:3] is the data word.
- take_no_action_ocimem_a  in  1  read-next strobe: read at the current address.
- ram_req  out  1  RAM access request.
- ram_wr  out  1  1=write, 0=read; valid while ram_req=1.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_ack  in  1  RAM access complete; ram_rdata is valid in the same cycle.
- ram_rdata  in  32  RAM read data.
- MonDReg  out  32  last read data.
- monitor_ready  out  1  last access completed.
- monitor_error  out  1  sticky error flag.

Function
REQ-005 The FSM SHALL have the states IDLE, WAIT_DATA, ACCESS and DONE.
REQ-006 IDLE + take_action_ocimem_a SHALL load addr, auto_inc and the read/write flag, clear monitor_ready and monitor_error, and go to ACCESS (read) or WAIT_DATA (write).
REQ-007 In WAIT_DATA, take_action_ocimem_b SHALL latch wdata and go to ACCESS.
REQ-008 IDLE + take_no_action_ocimem_a SHALL start a read at the current addr, clear monitor_ready and go to ACCESS.
REQ-009 ram_req SHALL assert the cycle after the triggering strobe and hold steady, with addr/wr/wdata constant, until ram_ack or timeout.
REQ-010 On ram_ack, ram_req SHALL drop in the same cycle, the next state SHALL be DONE, and on a read MonDReg SHALL be loaded with ram_rdata.
REQ-011 DONE SHALL assert monitor_ready, increment addr if auto_inc=1, and return to IDLE in one cycle.
REQ-012 monitor_ready SHALL stay at 1 until the next strobe that starts a command.
REQ-013 The increment SHALL wrap modulo 2^ADDR_W (for ADDR_W=8, address 0xFF goes to 0x00).
REQ-014 A strobe received outside IDLE or WAIT_DATA, and take_action_ocimem_b received in IDLE, SHALL be ignored and SHALL set monitor_error.
REQ-015 If take_action_ocimem_a and take_action_ocimem_b occur in the same cycle, take_action_ocimem_a SHALL take priority and take_action_ocimem_b SHALL be dropped without error.
REQ-016 If take_action_ocimem_a and take_no_action_ocimem_a occur in the same cycle, take_action_ocimem_a SHALL take priority.
REQ-017 In WAIT_DATA, take_action_ocimem_a SHALL restart the command: reload the fields and stay in WAIT_DATA or go to ACCESS according to jdo[35].
REQ-018 The only latency SHALL be: strobe to ram_req is 1 cycle, and ram_ack to monitor_ready is 2 cycles.

Reset
REQ-019 Assertion of reset_n low SHALL immediately force state IDLE, ram_req=0, ram_wr=0, ram_addr=0, ram_wdata=0, MonDReg=0, monitor_ready=0, monitor_error=0 and the timeout counter to 0, including in the middle of an access.
REQ-020 Reset release SHALL be synchronised to clk by the integrating level; the block samples reset_n only asynchronously.

Configuration
REQ-021 With the macro DECODER_OCI_TIMEOUT_EN defined, a counter SHALL run in ACCESS, and after TIMEOUT_CYC cycles without ram_ack the block SHALL drop ram_req, set monitor_error, leave MonDReg unchanged and go to DONE.
REQ-022 Without DECODER_OCI_TIMEOUT_EN, the counter SHALL be absent, ACCESS SHALL wait indefinitely, and monitor_error SHALL be set only per REQ-014.

Structure
REQ-023 A shared package SHALL hold the FSM state enum, the jdo field-position constants (read flag 35, auto-increment 34, address LSB 10, data 34:3) and the default TIMEOUT_CYC.
REQ-024 The timeout counter SHALL be a single sub-module named decoder_cpu_oci_timeout_cnt, with inputs clk, reset_n, run and clear and an output expired.
REQ-025 The rest of the block SHALL be flat RTL.

Verification
REQ-026 Read: take_action_ocimem_a with jdo[35]=1 and address 0x12, then ram_ack with ram_rdata=0xDEADBEEF after 3 cycles -> ram_addr=0x12, MonDReg=0xDEADBEEF, monitor_ready=1 two cycles after ram_ack.
REQ-027 Write: take_action_ocimem_a (write, address 0x05) then take_action_ocimem_b with data 0xA5A5A5A5 -> ram_req=1, ram_wr=1, ram_wdata=0xA5A5A5A5; after ram_ack, monitor_ready=1 and monitor_error=0.
REQ-028 Auto-increment wrap: read with auto-increment at address 0xFF, then take_no_action_ocimem_a -> the second access uses ram_addr=0x00.
REQ-029 Timeout (with DECODER_OCI_TIMEOUT_EN): read with ram_ack held at 0 -> ram_req drops after 15 cycles, monitor_error=1, monitor_ready=1, MonDReg unchanged.
REQ-030 Overrun and reset: take_action_ocimem_b issued while in ACCESS -> monitor_error=1 and the access completes normally; reset_n pulsed low mid-ACCESS -> ram_req=0 and all outputs 0 with no clock edge.

Source files
------------

// File: rtl/decoder_cpu_oci_access_sequencer_pkg.sv
// decoder_cpu_oci_access_sequencer_pkg: shared FSM states, jdo field positions and timeout default
package decoder_cpu_oci_access_sequencer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_ACCESS    = 2'd2,
        ST_DONE      = 2'd3
    } state_e;
    localparam int JDO_RD          = 35;
    localparam int JDO_AUTO        = 34;
    localparam int JDO_ADDR_LSB    = 10;
    localparam int JDO_DATA_MSB    = 34;
    localparam int JDO_DATA_LSB    = 3;
    localparam int TIMEOUT_CYC_DEF = 15;
endpackage

// File: rtl/decoder_cpu_oci_access_sequencer_timeout_cnt.sv
// decoder_cpu_oci_timeout_cnt: counts run cycles and flags expiry on the TIMEOUT_CYC-th one
module decoder_cpu_oci_timeout_cnt
    import decoder_cpu_oci_access_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = run && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = clear ? '0 : (run && !expired) ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/decoder_cpu_oci_access_sequencer.sv
// decoder_cpu_oci_access_sequencer: OCI debug-RAM access FSM; DECODER_OCI_TIMEOUT_EN enables the ram_ack timeout
module decoder_cpu_oci_access_sequencer
    import decoder_cpu_oci_access_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic              ram_req,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic              ram_ack,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              auto_q, auto_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mon_q, mon_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              expired;
    logic              any_strobe;
    logic              unused_jdo;

    assign unused_jdo    = ^{jdo[37:36], jdo[2:0]};
    assign any_strobe    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign ram_req       = (state_q == ST_ACCESS) && !ram_ack;
    assign ram_wr        = wr_q;
    assign ram_addr      = addr_q;
    assign ram_wdata     = wdata_q;
    assign MonDReg       = mon_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

`ifdef DECODER_OCI_TIMEOUT_EN
    decoder_cpu_oci_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (state_q == ST_ACCESS),
        .clear   (state_q != ST_ACCESS),
        .expired (expired)
    );
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = |TIMEOUT_CYC;
    assign expired            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        auto_d  = auto_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        mon_d   = mon_q;
        ready_d = ready_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE, ST_WAIT_DATA: begin
                // a wins over a concurrent b or read-next; the losing strobe is dropped silently
                if (take_action_ocimem_a) begin
                    addr_d  = jdo[JDO_ADDR_LSB +: ADDR_W];
                    auto_d  = jdo[JDO_AUTO];
                    wr_d    = !jdo[JDO_RD];
                    ready_d = 1'b0;
                    error_d = 1'b0;
                    state_d = jdo[JDO_RD] ? ST_ACCESS : ST_WAIT_DATA;
                end else if (state_q == ST_WAIT_DATA) begin
                    if (take_action_ocimem_b) begin
                        wdata_d = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                        state_d = ST_ACCESS;
                    end
                end else begin
                    if (take_no_action_ocimem_a) begin
                        wr_d    = 1'b0;
                        ready_d = 1'b0;
                        state_d = ST_ACCESS;
                    end
                    if (take_action_ocimem_b) error_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (ram_ack) begin
                    mon_d   = wr_q ? mon_q : ram_rdata;
                    state_d = ST_DONE;
                end else if (expired) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end
                if (any_strobe) error_d = 1'b1;
            end
            ST_DONE: begin
                ready_d = 1'b1;
                addr_d  = auto_q ? addr_q + ADDR_W'(1) : addr_q;
                state_d = ST_IDLE;
                if (any_strobe) error_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            auto_q  <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            mon_q   <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            auto_q  <= auto_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            mon_q   <= mon_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end
endmodule

// File: tb/tb_decoder_cpu_oci_access_sequencer.sv
// tb_decoder_cpu_oci_access_sequencer: directed scoreboard bench for the OCI access sequencer
module tb_decoder_cpu_oci_access_sequencer;
    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        ram_req;
    logic        ram_wr;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_ack = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    acc_t        exp_q[$];
    logic [31:0] m_mon = '0;
    logic [31:0] m_wdata = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    decoder_cpu_oci_access_sequencer dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .ram_req                 (ram_req),
        .ram_wr                  (ram_wr),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_ack                 (ram_ack),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] cmd(input logic rd, input logic ai, input logic [7:0] a);
        logic [37:0] j;
        j       = '0;
        j[35]   = rd;
        j[34]   = ai;
        j[17:10] = a;
        return j;
    endfunction

    function automatic logic [37:0] dat(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic a, input logic b, input logic na, input logic [37:0] j);
        jdo                     = j;
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = na;
        cyc();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic serve(input int dly, input logic [31:0] rd);
        acc_t e;
        int   n;
        n = 0;
        while (ram_req !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        check("req_latency", 32'(n), 32'd0);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL sb_empty: observed access with no expected entry");
            return;
        end
        e = exp_q.pop_front();
        check("ram_wr", 32'(ram_wr), 32'(e.wr));
        check("ram_addr", 32'(ram_addr), 32'(e.addr));
        check("ram_wdata", ram_wdata, e.wdata);
        repeat (dly) begin
            cyc();
            check("req_hold", {ram_req, 7'd0, ram_addr, ram_wdata[15:0]}, {1'b1, 7'd0, e.addr, e.wdata[15:0]});
        end
        ram_ack   = 1'b1;
        ram_rdata = rd;
        #1;
        check("req_drop", 32'(ram_req), 32'd0);
        if (!e.wr) m_mon = rd;
        cyc();
        ram_ack   = 1'b0;
        ram_rdata = '0;
        check("ready_done", 32'(monitor_ready), 32'd0);
        cyc();
        check("ready", 32'(monitor_ready), 32'd1);
        check("mondreg", MonDReg, m_mon);
    endtask

    initial begin
        int n;
        cyc();
        check("rst_req", 32'(ram_req), 32'd0);
        check("rst_outs", {ram_wr, monitor_ready, monitor_error, ram_addr}, 32'd0);
        check("rst_wdata", ram_wdata, 32'd0);
        check("rst_mon", MonDReg, 32'd0);
        reset_n = 1'b1;
        cyc();

        exp_q.push_back('{1'b0, 8'h12, m_wdata});
        strobe(1'b1, 1'b0, 1'b0, cmd(1'b1, 1'b0, 8'h12));
        serve(2, 32'hDEADBEEF);
        check("rd_error", 32'(monitor_error), 32'd0);

        strobe(1'b1, 1'b0, 1'b0, cmd(1'b0, 1'b0, 8'h05));
        check("wait_no_req", 32'(ram_req), 32'd0);
        check("cmd_clr_ready", 32'(monitor_ready), 32'd0);
        m_wdata = 32'hA5A5A5A5;
        exp_q.push_back('{1'b1, 8'h05, m_wdata});
        strobe(1'b0, 1'b1, 1'b0, dat(32'hA5A5A5A5));
        serve(1, 32'h11111111);
        check("wr_error", 32'(monitor_error), 32'd0);

        exp_q.push_back('{1'b0, 8'hFF, m_wdata});
        strobe(1'b1, 1'b0, 1'b0, cmd(1'b1, 1'b1, 8'hFF));
        serve(0, 32'h12345678);
        check("wrap_addr", 32'(ram_addr), 32'h00);
        exp_q.push_back('{1'b0, 8'h00, m_wdata});
        strobe(1'b0, 1'b0, 1'b1, '0);
        serve(2, 32'hCAFEF00D);
        check("inc_addr", 32'(ram_addr), 32'h01);

        exp_q.push_back('{1'b0, 8'h30, m_wdata});
        strobe(1'b1, 1'b0, 1'b0, cmd(1'b1, 1'b0, 8'h30));
        strobe(1'b0, 1'b1, 1'b0, dat(32'hFFFFFFFF));
        check("overrun_err", 32'(monitor_error), 32'd1);
        serve(1, 32'h0BADF00D);
        check("overrun_sticky", 32'(monitor_error), 32'd1);

        strobe(1'b0, 1'b1, 1'b0, dat(32'h77777777));
        check("b_idle_err", 32'(monitor_error), 32'd1);
        check("b_idle_ready", 32'(monitor_ready), 32'd1);
        check("b_idle_no_req", 32'(ram_req), 32'd0);

        strobe(1'b1, 1'b1, 1'b0, cmd(1'b0, 1'b0, 8'h40));
        check("ab_no_err", 32'(monitor_error), 32'd0);
        check("ab_wait", 32'(ram_req), 32'd0);
        m_wdata = 32'h0F0F0F0F;
        exp_q.push_back('{1'b1, 8'h40, m_wdata});
        strobe(1'b0, 1'b1, 1'b0, dat(32'h0F0F0F0F));
        serve(0, 32'h0);

        exp_q.push_back('{1'b0, 8'h22, m_wdata});
        strobe(1'b1, 1'b0, 1'b1, cmd(1'b1, 1'b0, 8'h22));
        serve(1, 32'h5555AAAA);

        strobe(1'b1, 1'b0, 1'b0, cmd(1'b0, 1'b0, 8'h50));
        exp_q.push_back('{1'b0, 8'h60, m_wdata});
        strobe(1'b1, 1'b0, 1'b0, cmd(1'b1, 1'b0, 8'h60));
        serve(3, 32'h13579BDF);

`ifdef DECODER_OCI_TIMEOUT_EN
        strobe(1'b1, 1'b0, 1'b0, cmd(1'b1, 1'b0, 8'h33));
        n = 0;
        while (ram_req === 1'b1 && n < 40) begin
            n++;
            cyc();
        end
        check("to_cycles", 32'(n), 32'd15);
        check("to_error", 32'(monitor_error), 32'd1);
        cyc();
        check("to_ready", 32'(monitor_ready), 32'd1);
        check("to_mon", MonDReg, m_mon);
`endif

        strobe(1'b1, 1'b0, 1'b0, cmd(1'b1, 1'b1, 8'h70));
        check("pre_rst_req", 32'(ram_req), 32'd1);
        check("pre_rst_addr", 32'(ram_addr), 32'h70);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(ram_req), 32'd0);
        check("rst_mid_outs", {ram_wr, monitor_ready, monitor_error, ram_addr}, 32'd0);
        check("rst_mid_wdata", ram_wdata, 32'd0);
        check("rst_mid_mon", MonDReg, 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        check("post_rst_req", 32'(ram_req), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
